// File: rtl/apex_dot_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apex_dot_engine_if                                           |
// | Description : Memory request/response bus between the dot-product engine   |
// |               and its memory.                                              |
// |               One request is issued at a time; each accepted request       |
// |               (read or write) returns exactly one response pulse.          |
// | Signals     : mem_req_valid/ready   request handshake                      |
// |               mem_req_addr          byte address (ADDR_W)                  |
// |               mem_req_we            1 = write, 0 = read                    |
// |               mem_req_wdata         write data (DATA_W)                    |
// |               mem_rsp_valid         one-cycle response pulse               |
// |               mem_rsp_rdata         read data (DATA_W)                     |
// | Modports    : master (engine side), slave (memory side)                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface apex_dot_engine_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_we;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid,
    input  mem_req_ready,
    output mem_req_addr,
    output mem_req_we,
    output mem_req_wdata,
    input  mem_rsp_valid,
    input  mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid,
    output mem_req_ready,
    input  mem_req_addr,
    input  mem_req_we,
    input  mem_req_wdata,
    output mem_rsp_valid,
    output mem_rsp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/apex_dot_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apex_dot_engine                                              |
// | Description : Signed dot product of two word vectors held in memory.       |
// |               Fetches A[i] and B[i] one word at a time, accumulates        |
// |               A[i]*B[i] modulo 2^DATA_W and writes the sum to i_out_addr.  |
// | Ports       : S_AXI_ACLK      clock                                        |
// |               S_AXI_ARESETN   asynchronous active-low reset                |
// |               i_ctrl          [0] start (rising edge), [1] clear-done      |
// |               i_a_base        vector A byte base address                   |
// |               i_b_base        vector B byte base address                   |
// |               i_out_addr      result byte address                          |
// |               i_len           element count (bits [15:0])                  |
// |               o_status        [0] busy, [1] done, [31:16] elements done    |
// |               mem             memory bus (apex_dot_engine_if.master)       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module apex_dot_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic [DATA_W-1:0] i_ctrl,
  input  logic [ADDR_W-1:0] i_a_base,
  input  logic [ADDR_W-1:0] i_b_base,
  input  logic [ADDR_W-1:0] i_out_addr,
  input  logic [DATA_W-1:0] i_len,
  output logic [DATA_W-1:0] o_status,
  apex_dot_engine_if.master mem
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ_A = 3'd1,
    RSP_A = 3'd2,
    REQ_B = 3'd3,
    RSP_B = 3'd4,
    REQ_W = 3'd5,
    RSP_W = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Operands captured at start; the run never looks at the live inputs again.
  logic [ADDR_W-1:0] r_a_base;
  logic [ADDR_W-1:0] r_b_base;
  logic [ADDR_W-1:0] r_out_addr;
  logic [15:0]       r_len;
  logic [15:0]       r_idx;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_a_val;
  logic              r_done;
  logic              r_start_prev;

  logic                     w_start;
  logic                     w_take_start;
  logic                     w_cap_a;
  logic                     w_accum;
  logic                     w_set_done;
  logic                     w_clr_done;
  logic                     w_last;
  logic                     w_req_valid;
  logic                     w_req_we;
  logic [ADDR_W-1:0]        w_req_addr;
  logic [DATA_W-1:0]        w_req_wdata;
  logic [ADDR_W-1:0]        w_idx_off;
  logic signed [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]        w_status;
  logic                     w_unused;

  assign w_start   = i_ctrl[0] & ~r_start_prev;
  assign w_last    = ((r_idx + 16'd1) == r_len);
  assign w_idx_off = ADDR_W'({r_idx, 2'b00});
  // Full-width signed product; only the low DATA_W bits feed the accumulator.
  assign w_prod    = $signed(r_a_val) * $signed(mem.mem_rsp_rdata);

  // Bits of the inputs/product that carry no meaning for this engine.
  assign w_unused  = ^{i_ctrl[DATA_W-1:2], i_len[DATA_W-1:16], w_prod[2*DATA_W-1:DATA_W]};

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next state, bus outputs and datapath strobes
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_take_start = 1'b0;
    w_cap_a      = 1'b0;
    w_accum      = 1'b0;
    w_set_done   = 1'b0;
    w_clr_done   = 1'b0;
    w_req_valid  = 1'b0;
    w_req_we     = 1'b0;
    w_req_addr   = '0;
    w_req_wdata  = '0;

    case (r_state)
      IDLE, DONE: begin
        if (w_start) begin
          // Start has priority over clear-done when both are present.
          w_take_start = 1'b1;
          w_state_nxt  = (i_len[15:0] == 16'd0) ? REQ_W : REQ_A;
        end else if (r_state == DONE && i_ctrl[1]) begin
          w_clr_done  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      REQ_A: begin
        w_req_valid = 1'b1;
        w_req_addr  = r_a_base + w_idx_off;
        if (mem.mem_req_ready) w_state_nxt = RSP_A;
      end
      RSP_A: begin
        if (mem.mem_rsp_valid) begin
          w_cap_a     = 1'b1;
          w_state_nxt = REQ_B;
        end
      end
      REQ_B: begin
        w_req_valid = 1'b1;
        w_req_addr  = r_b_base + w_idx_off;
        if (mem.mem_req_ready) w_state_nxt = RSP_B;
      end
      RSP_B: begin
        if (mem.mem_rsp_valid) begin
          w_accum     = 1'b1;
          w_state_nxt = w_last ? REQ_W : REQ_A;
        end
      end
      REQ_W: begin
        w_req_valid = 1'b1;
        w_req_we    = 1'b1;
        w_req_addr  = r_out_addr;
        w_req_wdata = r_acc;
        if (mem.mem_req_ready) w_state_nxt = RSP_W;
      end
      RSP_W: begin
        if (mem.mem_rsp_valid) begin
          w_set_done  = 1'b1;
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request fields are pure functions of state and registers that do not
  // move while a request is pending, so they stay stable until accepted.
  assign mem.mem_req_valid = w_req_valid;
  assign mem.mem_req_we    = w_req_we;
  assign mem.mem_req_addr  = w_req_addr;
  assign mem.mem_req_wdata = w_req_wdata;

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_start_prev <= 1'b0;
      r_a_base     <= '0;
      r_b_base     <= '0;
      r_out_addr   <= '0;
      r_len        <= '0;
      r_idx        <= '0;
      r_acc        <= '0;
      r_a_val      <= '0;
      r_done       <= 1'b0;
    end else begin
      r_start_prev <= i_ctrl[0];
      if (w_take_start) begin
        r_a_base   <= i_a_base;
        r_b_base   <= i_b_base;
        r_out_addr <= i_out_addr;
        r_len      <= i_len[15:0];
        r_idx      <= '0;
        r_acc      <= '0;
        r_done     <= 1'b0;
      end
      if (w_cap_a) begin
        r_a_val <= mem.mem_rsp_rdata;
      end
      if (w_accum) begin
        r_acc <= r_acc + w_prod[DATA_W-1:0];
        r_idx <= r_idx + 16'd1;
      end
      if (w_set_done) begin
        r_done <= 1'b1;
      end
      if (w_clr_done) begin
        r_done <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Status word
  // -------------------------------------------------------------------------
  always_comb begin
    w_status        = '0;
    w_status[0]     = (r_state != IDLE) && (r_state != DONE);
    w_status[1]     = r_done;
    w_status[31:16] = r_idx;
  end

  assign o_status = w_status;

endmodule
`default_nettype wire

// File: tb/tb_apex_dot_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_apex_dot_engine                                           |
// | Description : Directed self-checking bench for apex_dot_engine with a      |
// |               word-addressed memory model answering one cycle after each   |
// |               accepted request.                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_apex_dot_engine;

  localparam int c_DATA_W = 32;
  localparam int c_ADDR_W = 32;

  logic                S_AXI_ACLK    = 1'b0;
  logic                S_AXI_ARESETN = 1'b0;
  logic [c_DATA_W-1:0] r_ctrl        = '0;
  logic [c_ADDR_W-1:0] r_a_base      = '0;
  logic [c_ADDR_W-1:0] r_b_base      = '0;
  logic [c_ADDR_W-1:0] r_out_addr    = '0;
  logic [c_DATA_W-1:0] r_len         = '0;
  logic [c_DATA_W-1:0] w_status;

  logic                r_ready       = 1'b1;
  logic                r_mute        = 1'b0;
  logic                r_late        = 1'b0;
  logic [c_DATA_W-1:0] r_late_data   = '0;
  logic                r_rsp         = 1'b0;
  logic [c_DATA_W-1:0] r_rdata       = '0;

  logic [31:0]         mem [0:1023];
  int                  wr_count;
  int                  rd_count;
  logic [31:0]         last_wr_addr;
  logic [31:0]         last_wr_data;

  int                  total = 0;
  int                  bad   = 0;

  apex_dot_engine_if #(.DATA_W(c_DATA_W), .ADDR_W(c_ADDR_W)) bus ();

  apex_dot_engine #(.DATA_W(c_DATA_W), .ADDR_W(c_ADDR_W)) dut (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .i_ctrl        (r_ctrl),
    .i_a_base      (r_a_base),
    .i_b_base      (r_b_base),
    .i_out_addr    (r_out_addr),
    .i_len         (r_len),
    .o_status      (w_status),
    .mem           (bus)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  assign bus.mem_req_ready = r_ready;
  assign bus.mem_rsp_valid = r_rsp | r_late;
  assign bus.mem_rsp_rdata = r_late ? r_late_data : r_rdata;

  // Memory model: response pulse in the cycle after the handshake.
  always @(posedge S_AXI_ACLK) begin
    r_rsp <= 1'b0;
    if (bus.mem_req_valid && bus.mem_req_ready && !r_mute) begin
      r_rsp <= 1'b1;
      if (bus.mem_req_we) begin
        mem[bus.mem_req_addr[11:2]] = bus.mem_req_wdata;
        wr_count     = wr_count + 1;
        last_wr_addr = bus.mem_req_addr;
        last_wr_data = bus.mem_req_wdata;
      end else begin
        r_rdata  <= mem[bus.mem_req_addr[11:2]];
        rd_count = rd_count + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setup(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] o, input logic [31:0] n);
    r_a_base     = a;
    r_b_base     = b;
    r_out_addr   = o;
    r_len        = n;
    wr_count     = 0;
    rd_count     = 0;
    last_wr_addr = 32'hDEAD_BEEF;
    last_wr_data = 32'hDEAD_BEEF;
  endtask

  // Raises start just after a falling edge; returns 1 time unit after the
  // rising edge that samples it, with start lowered again.
  task automatic do_start();
    @(negedge S_AXI_ACLK);
    r_ctrl = 32'd1;
    @(posedge S_AXI_ACLK);
    #1;
    r_ctrl = 32'd0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n;
    n = 0;
    while (!w_status[1] && n < limit) begin
      @(posedge S_AXI_ACLK);
      #1;
      n++;
    end
    chk(tag, {63'd0, w_status[1]}, 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h040] = 32'd1;  mem[10'h041] = 32'd2;  mem[10'h042] = 32'd3;  mem[10'h043] = 32'd4;
    mem[10'h080] = 32'd5;  mem[10'h081] = 32'd6;  mem[10'h082] = 32'd7;  mem[10'h083] = 32'd8;
    mem[10'h100] = 32'd9;  mem[10'h101] = 32'd9;
    mem[10'h140] = 32'hFFFF_FFFD;  mem[10'h141] = 32'd7;
    mem[10'h180] = 32'h0001_0000;
    setup(32'h0, 32'h0, 32'h0, 32'h0);

    // ---- Reset state --------------------------------------------------------
    #2;
    chk("rst_status", w_status, 64'h0);
    chk("rst_valid",  bus.mem_req_valid, 64'h0);
    chk("rst_we",     bus.mem_req_we, 64'h0);
    chk("rst_addr",   bus.mem_req_addr, 64'h0);
    chk("rst_wdata",  bus.mem_req_wdata, 64'h0);
    repeat (2) @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 1'b1;

    // ---- Basic len=4 run: 70 at 0x300, done exactly 18 cycles after start ---
    setup(32'h100, 32'h200, 32'h300, 32'd4);
    do_start();
    chk("basic_first_addr", bus.mem_req_addr, 64'h100);
    repeat (17) @(posedge S_AXI_ACLK);
    #1;
    chk("basic_cyc17_status", w_status, 64'h0004_0001);
    @(posedge S_AXI_ACLK);
    #1;
    chk("basic_cyc18_status", w_status, 64'h0004_0002);
    chk("basic_wdata",  last_wr_data, 64'd70);
    chk("basic_waddr",  last_wr_addr, 64'h300);
    chk("basic_writes", wr_count, 64'd1);
    chk("basic_reads",  rd_count, 64'd8);

    // ---- len=0: single write of 0, no reads --------------------------------
    setup(32'h100, 32'h200, 32'h310, 32'd0);
    do_start();
    chk("len0_valid", bus.mem_req_valid, 64'd1);
    chk("len0_we",    bus.mem_req_we, 64'd1);
    chk("len0_addr",  bus.mem_req_addr, 64'h310);
    @(posedge S_AXI_ACLK);
    #1;
    chk("len0_rspw_status", w_status, 64'h1);
    @(posedge S_AXI_ACLK);
    #1;
    chk("len0_done_status", w_status, 64'h2);
    chk("len0_wdata",  last_wr_data, 64'd0);
    chk("len0_reads",  rd_count, 64'd0);
    chk("len0_writes", wr_count, 64'd1);

    // ---- Start and clear-done together in DONE: start wins -----------------
    setup(32'h100, 32'h200, 32'h310, 32'd0);
    @(negedge S_AXI_ACLK);
    r_ctrl = 32'd3;
    @(posedge S_AXI_ACLK);
    #1;
    r_ctrl = 32'd0;
    chk("startwins_status", w_status[1:0], 64'h1);
    wait_done("startwins_done", 50);

    // ---- len=1 signed product and product wrap -----------------------------
    setup(32'h500, 32'h504, 32'h320, 32'd1);
    do_start();
    wait_done("neg_done", 50);
    chk("neg_wdata", last_wr_data, 64'hFFFF_FFEB);
    chk("neg_idx",   w_status[31:16], 64'd1);

    setup(32'h600, 32'h600, 32'h324, 32'd1);
    do_start();
    wait_done("wrap_done", 50);
    chk("wrap_wdata", last_wr_data, 64'h0);

    // ---- Back-pressure: ready low 3 cycles on the B[1] request -------------
    setup(32'h100, 32'h200, 32'h300, 32'd4);
    do_start();
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge S_AXI_ACLK);
      if (bus.mem_req_valid && bus.mem_req_addr == 32'h204) found = 1'b1;
    end
    chk("stall_found", {63'd0, found}, 64'd1);
    r_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge S_AXI_ACLK);
      chk("stall_valid", bus.mem_req_valid, 64'd1);
      chk("stall_addr",  bus.mem_req_addr, 64'h204);
      chk("stall_we",    bus.mem_req_we, 64'd0);
    end
    r_ready = 1'b1;
    wait_done("stall_done", 60);
    chk("stall_wdata", last_wr_data, 64'd70);
    chk("stall_reads", rd_count, 64'd8);

    // ---- Second start and input changes mid-run are ignored ----------------
    setup(32'h100, 32'h200, 32'h300, 32'd4);
    do_start();
    repeat (5) @(posedge S_AXI_ACLK);
    @(negedge S_AXI_ACLK);
    r_ctrl   = 32'd1;
    r_a_base = 32'h400;
    r_len    = 32'd2;
    wait_done("midrun_done", 60);
    chk("midrun_wdata", last_wr_data, 64'd70);
    chk("midrun_waddr", last_wr_addr, 64'h300);
    chk("midrun_reads", rd_count, 64'd8);
    chk("midrun_idx",   w_status[31:16], 64'd4);
    @(negedge S_AXI_ACLK);
    r_ctrl = 32'd2;
    @(posedge S_AXI_ACLK);
    #1;
    chk("clrdone_status", w_status, 64'h0004_0000);
    r_ctrl = 32'd0;

    // ---- Reset pulse while waiting in RSP_B --------------------------------
    setup(32'h100, 32'h200, 32'h300, 32'd4);
    do_start();
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge S_AXI_ACLK);
      if (bus.mem_req_valid && bus.mem_req_addr == 32'h200) found = 1'b1;
    end
    chk("rstmid_found", {63'd0, found}, 64'd1);
    r_mute = 1'b1;
    @(negedge S_AXI_ACLK);
    chk("rstmid_pre_status", w_status, 64'h1);
    chk("rstmid_pre_valid",  bus.mem_req_valid, 64'd0);
    #2;
    S_AXI_ARESETN = 1'b0;
    #1;
    chk("rstmid_status", w_status, 64'h0);
    chk("rstmid_valid",  bus.mem_req_valid, 64'd0);
    @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 1'b1;
    r_mute        = 1'b0;
    @(negedge S_AXI_ACLK);
    r_late_data = 32'h0000_0011;
    r_late      = 1'b1;
    @(negedge S_AXI_ACLK);
    r_late = 1'b0;
    @(negedge S_AXI_ACLK);
    chk("late_status", w_status, 64'h0);
    chk("late_valid",  bus.mem_req_valid, 64'd0);
    setup(32'h100, 32'h200, 32'h330, 32'd4);
    do_start();
    wait_done("after_rst_done", 60);
    chk("after_rst_wdata", last_wr_data, 64'd70);
    chk("after_rst_waddr", last_wr_addr, 64'h330);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
